spi_slave_rx_mode1: RTL and testbench

- SPI mode-1 slave receiver (CPOL=0, CPHA=1) on the In_clk system clock; the receive end of the mode-1 SPI link, MSB first.
- Oversamples SCLK, CS_n and MOSI with synchronisers and detects SCLK falling edges.
- Assembles DATA_WIDTH-bit words and presents each completed word with a one-cycle valid strobe.
- Detects frames truncated by CS_n deassertion and flags them.

---
 rtl/spi_slave_rx_mode1_if.sv | 22 ++
 rtl/spi_slave_rx_mode1.sv | 113 +++++++++++
 tb/tb_spi_slave_rx_mode1.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_rx_mode1_if.sv
// rtl/spi_slave_rx_mode1_if.sv - SPI mode-1 receive link: serial inputs and received-word outputs
interface spi_slave_rx_mode1_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  In_spi_cs_n;
    logic                  In_spi_sclk;
    logic                  In_spi_mosi;
    logic [DATA_WIDTH-1:0] Out_rx_data;
    logic                  Out_rx_valid;
    logic                  Out_rx_busy;
    logic                  Out_frame_err;

    modport master (
        output In_spi_cs_n, In_spi_sclk, In_spi_mosi,
        input  Out_rx_data, Out_rx_valid, Out_rx_busy, Out_frame_err
    );

    modport slave (
        input  In_spi_cs_n, In_spi_sclk, In_spi_mosi,
        output Out_rx_data, Out_rx_valid, Out_rx_busy, Out_frame_err
    );
endinterface

// File: rtl/spi_slave_rx_mode1.sv
// rtl/spi_slave_rx_mode1.sv - SPI mode-1 (CPOL=0, CPHA=1) slave receiver, MSB first
module spi_slave_rx_mode1 #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  In_clk,
    input  logic                  In_rst_n,
    spi_slave_rx_mode1_if.slave   bus
);
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  cs_sync_q;
    logic [SYNC_STAGES-1:0]  sclk_sync_q;
    logic [SYNC_STAGES-1:0]  mosi_sync_q;
    logic                    sclk_prev_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic                    rx_valid_q;
    logic                    rx_busy_q;
    logic                    frame_err_q;

    logic                    cs_n_s;
    logic                    sclk_s;
    logic                    mosi_s;
    logic                    fall;
    logic                    word_done;
    logic [DATA_WIDTH-1:0]   shift_d;
    logic [CNT_W-1:0]        bit_cnt_d;

    // All three chains share one depth, so MOSI lines up with the detected SCLK edge.
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign fall   = sclk_prev_q & ~sclk_s;

    always_comb begin
        shift_d   = {shift_q[DATA_WIDTH-2:0], mosi_s};
        word_done = fall && (bit_cnt_q == LAST_BIT);
        bit_cnt_d = bit_cnt_q;
        if (fall) begin
            bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.In_spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.In_spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.In_spi_mosi};
            sclk_prev_q <= sclk_s;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    shift_q   <= '0;
                    bit_cnt_q <= '0;
                    if (!cs_n_s) begin
                        state_q   <= RECV;
                        rx_busy_q <= 1'b1;
                    end
                end
                RECV: begin
                    if (word_done) begin
                        rx_data_q  <= shift_d;
                        rx_valid_q <= 1'b1;
                    end
                    // A fall that completes the word in the same cycle CS_n rises leaves
                    // bit_cnt_d at zero, so the frame closes cleanly.
                    if (cs_n_s) begin
                        state_q     <= IDLE;
                        rx_busy_q   <= 1'b0;
                        shift_q     <= '0;
                        bit_cnt_q   <= '0;
                        frame_err_q <= (bit_cnt_d != '0);
                    end else if (fall) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Out_rx_data   = rx_data_q;
    assign bus.Out_rx_valid  = rx_valid_q;
    assign bus.Out_rx_busy   = rx_busy_q;
    assign bus.Out_frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_rx_mode1.sv
// tb/tb_spi_slave_rx_mode1.sv - testbench for the SPI mode-1 slave receiver
module tb_spi_slave_rx_mode1;
    localparam int SYNC = 2;
    localparam int HALF_NOM = 50;

    logic In_clk;
    logic In_rst_n;

    spi_slave_rx_mode1_if #(.DATA_WIDTH(8)) bus ();

    spi_slave_rx_mode1 #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
        .In_clk   (In_clk),
        .In_rst_n (In_rst_n),
        .bus      (bus)
    );

    initial In_clk = 1'b0;
    always #10 In_clk = ~In_clk;

    typedef struct {
        logic [7:0] w0, w1, w2;
        int         nwords;
        logic [7:0] trunc_word;
        int         trunc_bits;
        int         half;
        int         dly;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         err_seen   = 0;
    int         exp_err    = 0;
    int         busy_seen  = 0;
    int         multi_seen = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] model_data = 8'h00;

    always @(negedge In_clk) begin
        if (bus.Out_rx_valid) got_q.push_back(bus.Out_rx_data);
        if (bus.Out_frame_err) err_seen++;
        if (bus.Out_rx_busy) busy_seen++;
        if (bus.Out_rx_valid && valid_prev) multi_seen++;
        valid_prev = bus.Out_rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge In_clk);
            #3;
        end
    endtask

    task automatic spi_word(input logic [7:0] w, input int nbits, input int half,
                            input int dly, input bit cs_on_last);
        for (int i = 0; i < nbits; i++) begin
            bus.In_spi_sclk = 1'b1;
            tick(dly);
            bus.In_spi_mosi = w[7-i];
            tick(half - dly);
            if (cs_on_last && i == nbits - 1) bus.In_spi_cs_n = 1'b1;
            bus.In_spi_sclk = 1'b0;
            tick(half);
        end
    endtask

    // Sends every word in tx_q plus an optional truncated tail, and records what a
    // correct receiver must report: each full word in order, one error per tail.
    task automatic run_frame(input logic [7:0] trunc_word, input int trunc_bits,
                             input int half, input int dly, input bit cs_last);
        bus.In_spi_cs_n = 1'b0;
        tick(4);
        foreach (tx_q[i]) begin
            spi_word(tx_q[i], 8, half, dly, cs_last && (i == tx_q.size() - 1) && trunc_bits == 0);
            exp_q.push_back(tx_q[i]);
            model_data = tx_q[i];
        end
        if (trunc_bits > 0) begin
            spi_word(trunc_word, trunc_bits, half, dly, 1'b0);
            exp_err++;
        end
        bus.In_spi_cs_n = 1'b1;
        tick(8);
    endtask

    task automatic check_frame(input string tag);
        check({tag, " valid count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, " word"}, got_q[i], exp_q[i]);
        check({tag, " frame_err count"}, err_seen, exp_err);
        check({tag, " rx_data hold"}, bus.Out_rx_data, model_data);
        check({tag, " busy idle"}, bus.Out_rx_busy, 1'b0);
        got_q.delete();
        exp_q.delete();
        err_seen = 0;
        exp_err  = 0;
    endtask

    vec_t vt[6];

    initial begin
        In_rst_n        = 1'b0;
        bus.In_spi_cs_n = 1'b1;
        bus.In_spi_sclk = 1'b0;
        bus.In_spi_mosi = 1'b0;
        tick(3);
        check("reset rx_data", bus.Out_rx_data, 8'h00);
        check("reset rx_valid", bus.Out_rx_valid, 1'b0);
        check("reset rx_busy", bus.Out_rx_busy, 1'b0);
        check("reset frame_err", bus.Out_frame_err, 1'b0);
        In_rst_n = 1'b1;
        tick(4);

        // Busy timing around a nominal 0xA5 frame.
        tx_q = '{8'hA5};
        bus.In_spi_cs_n = 1'b0;
        repeat (SYNC) @(posedge In_clk);
        @(negedge In_clk);
        check("busy before sync", bus.Out_rx_busy, 1'b0);
        @(posedge In_clk);
        @(negedge In_clk);
        check("busy after cs low", bus.Out_rx_busy, 1'b1);
        @(posedge In_clk);
        #3;
        tick(3);
        spi_word(8'hA5, 8, HALF_NOM, 1, 1'b0);
        exp_q.push_back(8'hA5);
        model_data = 8'hA5;
        bus.In_spi_cs_n = 1'b1;
        repeat (SYNC) @(posedge In_clk);
        @(negedge In_clk);
        check("busy held before cs sync", bus.Out_rx_busy, 1'b1);
        @(posedge In_clk);
        @(negedge In_clk);
        check("busy drop after cs high", bus.Out_rx_busy, 1'b0);
        tick(4);
        check_frame("busy A5");

        vt[0] = '{8'hA5, 8'h00, 8'h00, 1, 8'h00, 0, HALF_NOM, 1};
        vt[1] = '{8'h00, 8'h01, 8'hFF, 3, 8'h00, 0, HALF_NOM, 1};
        vt[2] = '{8'h00, 8'h00, 8'h00, 0, 8'h3C, 5, HALF_NOM, 1};
        vt[3] = '{8'h3C, 8'h00, 8'h00, 1, 8'h00, 0, HALF_NOM, 1};
        vt[4] = '{8'h5A, 8'h00, 8'h00, 1, 8'h00, 0, 6, 1};
        vt[5] = '{8'hC3, 8'h00, 8'h00, 1, 8'h00, 0, 6, 1};
        for (int v = 0; v < 6; v++) begin
            tx_q.delete();
            if (vt[v].nwords > 0) tx_q.push_back(vt[v].w0);
            if (vt[v].nwords > 1) tx_q.push_back(vt[v].w1);
            if (vt[v].nwords > 2) tx_q.push_back(vt[v].w2);
            run_frame(vt[v].trunc_word, vt[v].trunc_bits, vt[v].half, vt[v].dly, 1'b0);
            check_frame($sformatf("vec%0d", v));
        end

        // Last falling edge coincides with CS_n rising: word completes, no error.
        tx_q = '{8'h96};
        run_frame(8'h00, 0, 5, 1, 1'b1);
        check_frame("cs with last fall");

        // SCLK activity with CS_n high must be ignored.
        busy_seen = 0;
        for (int i = 0; i < 16; i++) begin
            bus.In_spi_sclk = 1'b1;
            tick(1);
            bus.In_spi_mosi = ~bus.In_spi_mosi;
            tick(3);
            bus.In_spi_sclk = 1'b0;
            tick(4);
        end
        tick(6);
        check("idle busy seen", busy_seen, 0);
        check_frame("idle sclk");

        // Reset in the middle of a frame, CS_n held low through it.
        bus.In_spi_cs_n = 1'b0;
        tick(4);
        spi_word(8'h81, 4, 5, 1, 1'b0);
        In_rst_n = 1'b0;
        #1;
        check("midreset rx_data", bus.Out_rx_data, 8'h00);
        check("midreset rx_busy", bus.Out_rx_busy, 1'b0);
        check("midreset rx_valid", bus.Out_rx_valid, 1'b0);
        check("midreset frame_err", bus.Out_frame_err, 1'b0);
        model_data = 8'h00;
        tick(3);
        In_rst_n = 1'b1;
        tx_q = '{8'h81};
        run_frame(8'h00, 0, 5, 1, 1'b0);
        check_frame("after reset");

        // Randomised frames against the queue model.
        for (int f = 0; f < 12; f++) begin
            int nw, half, dly, tb_bits;
            nw   = $urandom_range(1, 3);
            half = $urandom_range(4, 10);
            dly  = $urandom_range(0, half - 1);
            tb_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            tx_q.delete();
            for (int k = 0; k < nw; k++) tx_q.push_back(8'($urandom));
            run_frame(8'($urandom), tb_bits, half, dly, (tb_bits == 0) && ($urandom_range(0, 1) == 1));
            check_frame($sformatf("rand%0d", f));
        end

        check("valid strobe single-cycle", multi_seen, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
